// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32 opcode constants, stage FSM encoding and immediate-type selects
// Shared by the decode stage and immGenerator so both agree on opcode and imm-type encodings.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } stage_state_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_SB   = 3'd3,
    IMM_U    = 3'd4,
    IMM_UJ   = 3'd5
  } imm_type_e;

  typedef struct packed {
    logic iload;
    logic s;
    logic sb;
    logic u;
    logic uj;
  } imm_sel_t;

  // Expands the encoded imm type into the one-hot select lines immGenerator expects.
  function automatic imm_sel_t imm_onehot(input imm_type_e t);
    imm_sel_t sel;
    sel       = '0;
    sel.iload = (t == IMM_I);
    sel.s     = (t == IMM_S);
    sel.sb    = (t == IMM_SB);
    sel.u     = (t == IMM_U);
    sel.uj    = (t == IMM_UJ);
    return sel;
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// rtl/opcode_decoder.sv - combinational opcode to immediate-type and illegal flag
module opcode_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output imm_type_e  imm_type,
  output logic       illegal
);

  always_comb begin
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: imm_type = IMM_I;
      OPC_STORE:                                 imm_type = IMM_S;
      OPC_BRANCH:                                imm_type = IMM_SB;
      OPC_LUI, OPC_AUIPC:                        imm_type = IMM_U;
      OPC_JAL:                                   imm_type = IMM_UJ;
      OPC_OP:                                    imm_type = IMM_NONE;
      default:                                   illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_decode_stage.sv
// rtl/inst_decode_stage.sv - IF/ID register with opcode decode, valid/ready and flush FSM
// Register fields are sliced from the registered payload, so bubbles clear them for free.
module inst_decode_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            nop,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [24:0]     Inst,
  output logic            ILoad,
  output logic            S,
  output logic            SB,
  output logic            U,
  output logic            UJ,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic            funct7b5,
  output logic [XLEN-1:0] pc_o,
  output logic            illegal
);

  stage_state_e    state, state_d;
  imm_type_e       dec_type;
  logic            dec_illegal;
  logic            load, clear;
  logic            valid_q, illegal_q;
  imm_sel_t        sel_q;
  logic [24:0]     inst_q;
  logic [XLEN-1:0] pc_q;

  opcode_decoder u_dec (
    .opcode   (inst_i[6:0]),
    .imm_type (dec_type),
    .illegal  (dec_illegal)
  );

  // rst_n gates in_ready so nothing is offered as accepted while reset is held.
  always_comb begin
    in_ready = rst_n && (state == ST_RUN) && !nop && (!valid_q || out_ready);
    state_d  = state;
    load     = 1'b0;
    clear    = 1'b0;
    case (state)
      ST_RUN: begin
        if (nop) begin
          state_d = ST_FLUSH;
          clear   = 1'b1;
        end else if (in_valid && in_ready) begin
          load = 1'b1;
        end else if (out_ready || !valid_q) begin
          clear = 1'b1;
        end
      end
      ST_FLUSH: begin
        state_d = ST_HOLD;
        clear   = 1'b1;
      end
      ST_HOLD: begin
        state_d = ST_RUN;
        clear   = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        clear   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      sel_q     <= '0;
      inst_q    <= '0;
      pc_q      <= RESET_PC;
    end else begin
      state <= state_d;
      if (load) begin
        valid_q   <= 1'b1;
        illegal_q <= dec_illegal;
        sel_q     <= imm_onehot(dec_type);
        inst_q    <= inst_i[31:7];
        pc_q      <= pc_i;
      end else if (clear) begin
        // pc_o keeps the last real pc; only the decoded payload is squashed.
        valid_q   <= 1'b0;
        illegal_q <= 1'b0;
        sel_q     <= '0;
        inst_q    <= '0;
      end
    end
  end

  assign out_valid = valid_q;
  assign Inst      = inst_q;
  assign ILoad     = sel_q.iload;
  assign S         = sel_q.s;
  assign SB        = sel_q.sb;
  assign U         = sel_q.u;
  assign UJ        = sel_q.uj;
  assign illegal   = illegal_q;
  assign pc_o      = pc_q;
  assign rd        = inst_q[4:0];
  assign funct3    = inst_q[7:5];
  assign rs1       = inst_q[12:8];
  assign rs2       = inst_q[17:13];
  assign funct7b5  = inst_q[23];

endmodule
